// File: rtl/otter_immed_gen_pipe.sv
// Pipelined OTTER immediate generator: opcode-driven format decode, XLEN-wide
// immediate construction, and STAGES elastic valid/ready register slots.
module otter_immed_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 1,
  parameter int CSR_IMM = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic [31:0]     IR,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [XLEN-1:0] IMM,
  output logic [2:0]      IMM_FMT,
  output logic            ILLEGAL,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_Z     = 3'd6,
    FMT_SHAMT = 3'd7
  } imm_fmt_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  imm_fmt_e        fmt_d;
  logic            illegal_d;
  logic [31:0]     word_d;
  logic            sext_d;
  logic [XLEN-1:0] imm_d;

  assign opcode = IR[6:0];
  assign funct3 = IR[14:12];

  always_comb begin
    fmt_d     = FMT_NONE;
    illegal_d = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111:            fmt_d = FMT_U;
      7'b1101111:                        fmt_d = FMT_J;
      7'b1100111, 7'b0000011, 7'b0001111: fmt_d = FMT_I;
      7'b0010011: fmt_d = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0100011:                        fmt_d = FMT_S;
      7'b1100011:                        fmt_d = FMT_B;
      7'b1110011: fmt_d = (CSR_IMM != 0 && funct3[2]) ? FMT_Z : FMT_I;
      7'b0110011:                        fmt_d = FMT_NONE;
      default:                           illegal_d = 1'b1;
    endcase
  end

  // Every format is first built as a 32-bit word, then widened either with
  // sign or zero extension so the XLEN=32 and XLEN=64 cases share one path.
  always_comb begin
    word_d = 32'd0;
    sext_d = 1'b0;
    case (fmt_d)
      FMT_I: begin
        word_d = {{20{IR[31]}}, IR[31:20]};
        sext_d = 1'b1;
      end
      FMT_S: begin
        word_d = {{20{IR[31]}}, IR[31:25], IR[11:7]};
        sext_d = 1'b1;
      end
      FMT_B: begin
        word_d = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
        sext_d = 1'b1;
      end
      FMT_U: begin
        word_d = {IR[31:12], 12'b0};
        sext_d = 1'b1;
      end
      FMT_J: begin
        word_d = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
        sext_d = 1'b1;
      end
      FMT_Z:     word_d = {27'b0, IR[19:15]};
      FMT_SHAMT: word_d = {26'b0, (XLEN == 64) ? IR[25] : 1'b0, IR[24:20]};
      default:   word_d = 32'd0;
    endcase
  end

  assign imm_d = sext_d ? XLEN'(signed'(word_d)) : XLEN'(word_d);

  logic            valid_q  [STAGES];
  logic [XLEN-1:0] imm_q    [STAGES];
  logic [2:0]      fmt_q    [STAGES];
  logic            ill_q    [STAGES];
  logic            up_valid [STAGES];
  logic [XLEN-1:0] up_imm   [STAGES];
  logic [2:0]      up_fmt   [STAGES];
  logic            up_ill   [STAGES];
  logic            rdy      [STAGES+1];

  assign rdy[STAGES] = OUT_READY;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    if (k == 0) begin : g_head
      assign up_valid[k] = IN_VALID;
      assign up_imm[k]   = imm_d;
      assign up_fmt[k]   = fmt_d;
      assign up_ill[k]   = illegal_d;
    end else begin : g_body
      assign up_valid[k] = valid_q[k-1];
      assign up_imm[k]   = imm_q[k-1];
      assign up_fmt[k]   = fmt_q[k-1];
      assign up_ill[k]   = ill_q[k-1];
    end

    assign rdy[k] = !valid_q[k] || rdy[k+1];

    // A ready slot always takes its upstream valid; data only moves on a real transfer.
    always_ff @(posedge CLK) begin
      if (RST) begin
        valid_q[k] <= 1'b0;
        imm_q[k]   <= '0;
        fmt_q[k]   <= 3'd0;
        ill_q[k]   <= 1'b0;
      end else if (FLUSH) begin
        valid_q[k] <= 1'b0;
      end else if (rdy[k]) begin
        valid_q[k] <= up_valid[k];
        if (up_valid[k]) begin
          imm_q[k] <= up_imm[k];
          fmt_q[k] <= up_fmt[k];
          ill_q[k] <= up_ill[k];
        end
      end
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = valid_q[STAGES-1];
  assign IMM       = imm_q[STAGES-1];
  assign IMM_FMT   = fmt_q[STAGES-1];
  assign ILLEGAL   = ill_q[STAGES-1];

endmodule

// File: doc/otter_immed_gen_pipe.md
Name: otter_immed_gen_pipe

Overview:
- Parametrised, pipelined successor to the OTTER immediate generator.
- Decodes the instruction format from the opcode and produces one selected, sign/zero-extended immediate of width XLEN plus a format tag.
- Registered through STAGES elastic pipeline slots with a valid/ready handshake and flush.
- Sits between fetch/IR register and the decode/execute stage. Handles shift-amount and CSR zimm immediates, which the combinational generator does not.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- STAGES, 1, number of register slots between input and output; legal values 1..3.
- CSR_IMM, 1, when 1 decode CSR zimm (format Z); when 0 CSR-immediate ops report format I.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- FLUSH  in  1  synchronous pipeline kill, same effect on valids as RST.
- IR  in  32  instruction word.
- IN_VALID  in  1  IR is valid this cycle.
- IN_READY  out  1  block accepts IR this cycle.
- IMM  out  XLEN  selected immediate.
- IMM_FMT  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT.
- ILLEGAL  out  1  opcode has no defined immediate format (IMM_FMT=NONE).
- OUT_VALID  out  1  IMM/IMM_FMT/ILLEGAL valid.
- OUT_READY  in  1  consumer accepts output this cycle.

Behaviour:
- Opcode[6:0] decode:
  - 0110111 and 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0001111 -> I.
  - 0010011 -> I, except SHAMT when funct3 is 001 or 101.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1110011 -> Z when CSR_IMM=1 and funct3[2]=1; otherwise I.
  - 0110011 -> NONE, ILLEGAL=0 (R-type, no immediate).
  - Any other opcode -> NONE, ILLEGAL=1.
- Immediate construction:
  - I, S, B, J, U all sign-extend from IR[31] to XLEN.
  - U = {IR[31:12],12'b0}, sign-extended to XLEN; bits [XLEN-1:32] equal IR[31] when XLEN=64.
  - B and J bit 0 is always 0.
  - SHAMT = zero-extended IR[24:20] when XLEN=32, IR[25:20] when XLEN=64.
  - Z = zero-extended IR[19:15].
  - NONE -> IMM=0.
- Pipeline:
  - Slot k holds {valid, IMM, IMM_FMT, ILLEGAL}. Decode is combinational ahead of slot 0; outputs come from slot STAGES-1. Latency is STAGES cycles from accept to OUT_VALID, with no back-pressure.
  - Slot ready_k = !valid_k || ready_(k+1); ready_STAGES = OUT_READY; IN_READY = ready_0.
  - Transfer happens only when valid && ready are both high on the same edge. A slot loads when its upstream transfers and holds when it is not ready.
  - Full throughput: with OUT_READY held at 1, one result per cycle.
  - Outputs are stable while OUT_VALID=1 and OUT_READY=0. IN_VALID=1 with IN_READY=0 leaves IR unaccepted; the producer must hold it.
  - Simultaneous push into a full final slot and pop from it is legal and replaces the data.
- Reset and flush:
  - RST clears all valids, IMM, IMM_FMT and ILLEGAL to 0. This gives OUT_VALID=0, IN_READY=1 the cycle after reset.
  - RST mid-stream discards all in-flight entries.
  - FLUSH clears all valids. Data registers may hold stale values.
  - An input presented in the FLUSH cycle is dropped; IN_READY may be 1, but the entry is not captured.
  - RST has priority over FLUSH.
- No combinational path from IN_VALID to OUT_VALID. OUT_READY-to-IN_READY combinational path is permitted.

Test Plan:
- XLEN=32, STAGES=1, IR=0xFFF00093 (addi x1,x0,-1), OUT_READY=1 -> next cycle OUT_VALID=1, IMM=0xFFFFFFFF, IMM_FMT=1, ILLEGAL=0.
- XLEN=64, IR=0x800000B7 (lui) -> IMM=0xFFFFFFFF80000000, IMM_FMT=4; IR=0xFE000EE3 (beq -4) -> IMM=0xFFFFFFFFFFFFFFFC, IMM_FMT=3.
- IR=0x4030D093 (srai x1,x1,3) -> IMM=3, IMM_FMT=7; IR=0x3002D073 (csrrwi) with CSR_IMM=1 -> IMM=5, IMM_FMT=6; with CSR_IMM=0 -> IMM=0x300, IMM_FMT=1.
- STAGES=3, stream 5 distinct IRs back-to-back, OUT_READY=0 for cycles 2-6 then 1 -> IN_READY falls after 3 accepts; all 5 results emerge in order, none lost or duplicated; outputs stable while stalled.
- Pipeline full, assert FLUSH for 1 cycle with IN_VALID=1 -> next cycle OUT_VALID=0 and the flushed-cycle IR is absent from the output stream; RST asserted mid-stream -> next cycle IMM=0, IMM_FMT=0, OUT_VALID=0, IN_READY=1.
- IR=0x0000007F (undefined opcode) -> IMM=0, IMM_FMT=0, ILLEGAL=1; IR=0x00000033 (R-type) -> ILLEGAL=0, IMM_FMT=0.
